// File: rtl/aba_pkg.sv
// Shared types and constants for the ABA result collector slice.
package aba_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } collect_state_t;

endpackage

// File: rtl/aba_result_collector_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush and a registered-storage read port.
// The head word comes from storage only, so a word written at edge N is readable after edge N.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]     r_wrPtr;
    logic [IDX_W:0]     r_rdPtr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_doPush;
    logic               w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[IDX_W] != r_rdPtr[IDX_W]) &&
                      (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_count  = r_wrPtr - r_rdPtr;
    assign o_rdata  = o_empty ? '0 : r_mem[r_rdPtr[IDX_W-1:0]];

    // Advance pointers on accepted push/pop; a flush discards both and empties the FIFO.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    // Write the incoming word into the tail slot; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) r_mem[r_wrPtr[IDX_W-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/aba_result_collector.sv
// Collects one batch of ABA output words into a FIFO and drains it to a ready/valid reader.
// Tracks batch progress, signals completion and keeps sticky overflow/dropped flags.
module aba_result_collector
    import aba_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         batch_len,
    input  logic                     clear,
    input  logic                     aba_valid,
    input  logic [WORD_W-1:0]        aba_values,
    input  logic                     aba_overflow,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WORD_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     dropped
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    collect_state_t     r_state;
    collect_state_t     w_nextState;
    logic [CNT_W-1:0]   r_batchLen;
    logic [CNT_W-1:0]   r_received;
    logic [CNT_W-1:0]   w_receivedInc;
    logic               r_done;
    logic               r_overflow;
    logic               r_dropped;
    logic               w_full;
    logic               w_empty;
    logic [OCC_W-1:0]   w_count;
    logic               w_push;
    logic               w_pop;
    logic               w_lastPush;
    logic               w_drainEnd;
    logic               w_goDone;
    logic               w_startBatch;

    assign w_pop         = !w_empty && rd_ready && !clear;
    assign w_push        = aba_valid && (r_state == COLLECT) && (!w_full || w_pop) && !clear;
    assign w_receivedInc = r_received + CNT_W'(1);
    assign w_lastPush    = w_push && (w_receivedInc == r_batchLen);
    assign w_drainEnd    = w_empty || ((w_count == OCC_W'(1)) && w_pop);
    assign w_startBatch  = (r_state == IDLE) && start && (batch_len != '0);

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_flush (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (aba_values),
        .o_rdata (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Batch state register; clear forces IDLE ahead of any transition.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: start a batch, move to DRAIN on the last accepted word, finish once the FIFO empties.
    always_comb begin
        w_nextState = r_state;
        w_goDone    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startBatch) w_nextState = COLLECT;
            end
            COLLECT: begin
                if (w_lastPush) w_nextState = DRAIN;
            end
            DRAIN: begin
                if (w_drainEnd) begin
                    w_nextState = IDLE;
                    w_goDone    = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Batch length, received count, done pulse and sticky flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_batchLen <= '0;
            r_received <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else if (clear) begin
            r_received <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_done <= w_goDone;
            if (w_startBatch) begin
                r_batchLen <= batch_len;
                r_received <= '0;
            end else if (w_push) begin
                r_received <= w_receivedInc;
            end
            if (w_push && aba_overflow) r_overflow <= 1'b1;
            if (aba_valid && !w_push)   r_dropped  <= 1'b1;
        end
    end

    assign rd_valid = !w_empty;
    assign count    = w_count;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;

endmodule
